// File: rtl/game_vga_timing.sv
// Pixel-rate divider, raster counters and the VGA output stage for game_top.
// Blanking and sync are delayed so they line up with the game's rgb latency.
`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 12
`endif

module game_vga_timing #(
    parameter int clk_mhz         = 50,
    parameter int pixel_mhz       = 25,
    parameter int screen_width    = 640,
    parameter int screen_height   = 480,
    parameter int h_front         = 16,
    parameter int h_sync          = 96,
    parameter int h_back          = 48,
    parameter int v_front         = 10,
    parameter int v_sync          = 2,
    parameter int v_back          = 33,
    parameter bit sync_active_low = 1'b1,
    parameter int rgb_latency     = 1,
    localparam int w_x = $clog2(screen_width),
    localparam int w_y = $clog2(screen_height)
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        pixel_en,
    output logic [w_x-1:0]              x,
    output logic [w_y-1:0]              y,
    output logic                        display_on,
    output logic                        frame_start,
    input  logic [`GAME_RGB_WIDTH-1:0]  rgb_in,
    output logic [`GAME_RGB_WIDTH-1:0]  vga_rgb,
    output logic                        vga_hsync,
    output logic                        vga_vsync
);

    localparam int DIV     = clk_mhz / pixel_mhz;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int H_TOTAL = screen_width + h_front + h_sync + h_back;
    localparam int V_TOTAL = screen_height + v_front + v_sync + v_back;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT    = H_W'(screen_width);
    localparam logic [V_W-1:0]   V_ACT    = V_W'(screen_height);
    localparam logic [H_W-1:0]   HS_FIRST = H_W'(screen_width + h_front);
    localparam logic [H_W-1:0]   HS_LAST  = H_W'(screen_width + h_front + h_sync - 1);
    localparam logic [V_W-1:0]   VS_FIRST = V_W'(screen_height + v_front);
    localparam logic [V_W-1:0]   VS_LAST  = V_W'(screen_height + v_front + v_sync - 1);
    localparam logic             SYNC_IDLE = sync_active_low ? 1'b1 : 1'b0;

    if ((clk_mhz % pixel_mhz) != 0) begin : g_bad_ratio
        $error("game_vga_timing: clk_mhz must be an integer multiple of pixel_mhz");
    end
    if (DIV < 1) begin : g_bad_div
        $error("game_vga_timing: pixel_mhz must not exceed clk_mhz");
    end
    if (rgb_latency < 0 || rgb_latency > 7) begin : g_bad_latency
        $error("game_vga_timing: rgb_latency must be within 0..7");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic             tick;
    logic             active_now;
    logic             hs_raw;
    logic             vs_raw;
    logic             de_d;
    logic             hs_d;
    logic             vs_d;

    assign tick       = (div_cnt == DIV_LAST);
    assign active_now = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Vertical count advances on the same pixel that wraps the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Scan outputs are presented from the counter values before they advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_en    <= 1'b0;
            frame_start <= 1'b0;
            display_on  <= 1'b0;
            x           <= '0;
            y           <= '0;
            hs_raw      <= 1'b0;
            vs_raw      <= 1'b0;
        end else begin
            pixel_en    <= tick;
            frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
            if (tick) begin
                display_on <= active_now;
                x          <= active_now ? h_cnt[w_x-1:0] : '0;
                y          <= active_now ? v_cnt[w_y-1:0] : '0;
                hs_raw     <= (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
                vs_raw     <= (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
            end
        end
    end

    if (rgb_latency == 0) begin : g_no_delay
        assign de_d = display_on;
        assign hs_d = hs_raw;
        assign vs_d = vs_raw;
    end else begin : g_delay
        logic [rgb_latency-1:0] de_sr;
        logic [rgb_latency-1:0] hs_sr;
        logic [rgb_latency-1:0] vs_sr;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                de_sr <= '0;
                hs_sr <= '0;
                vs_sr <= '0;
            end else begin
                de_sr[0] <= display_on;
                hs_sr[0] <= hs_raw;
                vs_sr[0] <= vs_raw;
                for (int i = 1; i < rgb_latency; i++) begin
                    de_sr[i] <= de_sr[i-1];
                    hs_sr[i] <= hs_sr[i-1];
                    vs_sr[i] <= vs_sr[i-1];
                end
            end
        end

        assign de_d = de_sr[rgb_latency-1];
        assign hs_d = hs_sr[rgb_latency-1];
        assign vs_d = vs_sr[rgb_latency-1];
    end

    // Final stage: blank colour, and apply sync polarity only here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_rgb   <= '0;
            vga_hsync <= SYNC_IDLE;
            vga_vsync <= SYNC_IDLE;
        end else begin
            vga_rgb   <= de_d ? rgb_in : '0;
            vga_hsync <= hs_d ^ SYNC_IDLE;
            vga_vsync <= vs_d ^ SYNC_IDLE;
        end
    end

endmodule
